// File: rtl/sonar_sweep_frame.sv
// rtl/sonar_sweep_frame.sv - sonar sweep sequencer and ASCII telemetry framer
//
// Steps a servo through N_POS positions (triangle or sawtooth order), settles,
// requests one HC-SR04 measurement with a timeout, then sends the 8-character
// frame "AAA,DDD#" one character at a time to the serial transmitter.
//
// Ports:
//   clock, reset    system clock, asynchronous active-high reset
//   ligar           sweep enable (level, sampled in OCIOSO and PROXIMO only)
//   medir           one-cycle measurement request
//   pronto_medida   one-cycle pulse, medida valid
//   medida          measured distance, 3 BCD digits
//   tx_partida      one-cycle transmit start
//   tx_dados        ASCII character, held until tx_pronto
//   tx_pronto       one-cycle pulse, character sent
//   posicao         current servo position index
//   angulo          BCD angle of posicao
//   distancia       last captured distance (12'hFFF after a timeout)
//   fim_varredura   one-cycle pulse when a sweep end point is reached
//   db_estado       FSM state code
`timescale 1ns/1ps
module sonar_sweep_frame #(
  parameter int N_POS     = 8,
  parameter int POS_W     = 3,
  parameter int MODO      = 0,
  parameter int INTERVALO = 200_000_000,
  parameter int TIMEOUT   = 2_500_000,
  parameter int ANG_BASE  = 20,
  parameter int ANG_STEP  = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ligar,
  output logic             medir,
  input  logic             pronto_medida,
  input  logic [11:0]      medida,
  output logic             tx_partida,
  output logic [6:0]       tx_dados,
  input  logic             tx_pronto,
  output logic [POS_W-1:0] posicao,
  output logic [11:0]      angulo,
  output logic [11:0]      distancia,
  output logic             fim_varredura,
  output logic [2:0]       db_estado
);

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    POSICIONA  = 3'd1,
    MEDE       = 3'd2,
    ESPERA     = 3'd3,
    TRANSMITE  = 3'd4,
    AGUARDA_TX = 3'd5,
    PROXIMO    = 3'd6
  } state_t;

  localparam logic [POS_W-1:0] LAST    = POS_W'(N_POS - 1);
  localparam logic [POS_W-1:0] LAST_M1 = POS_W'((N_POS > 1) ? N_POS - 2 : 0);
  localparam logic [POS_W-1:0] ONE     = POS_W'(1);

  state_t      state;
  logic [31:0] settle_cnt;
  logic [31:0] to_cnt;
  logic        up;
  logic [2:0]  idx;

  // Angle in binary never exceeds 999, so 10 bits are enough.
  logic [9:0] ang;
  logic [3:0] ang_h, ang_t, ang_u;
  logic [6:0] frame_char;

  assign ang    = 10'(ANG_BASE) + 10'(posicao) * 10'(ANG_STEP);
  assign ang_h  = 4'(ang / 10'd100);
  assign ang_t  = 4'((ang / 10'd10) % 10'd10);
  assign ang_u  = 4'(ang % 10'd10);
  assign angulo = {ang_h, ang_t, ang_u};

  assign db_estado = state;

  // Non-decimal digits (e.g. the 4'hF of a timeout) print as '-'.
  function automatic logic [6:0] ascii_digit(input logic [3:0] d);
    return (d > 4'd9) ? 7'h2D : {3'b011, d};
  endfunction

  always_comb begin
    frame_char = 7'h23;
    case (idx)
      3'd0: frame_char = ascii_digit(angulo[11:8]);
      3'd1: frame_char = ascii_digit(angulo[7:4]);
      3'd2: frame_char = ascii_digit(angulo[3:0]);
      3'd3: frame_char = 7'h2C;
      3'd4: frame_char = ascii_digit(distancia[11:8]);
      3'd5: frame_char = ascii_digit(distancia[7:4]);
      3'd6: frame_char = ascii_digit(distancia[3:0]);
      default: frame_char = 7'h23;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= OCIOSO;
      settle_cnt    <= '0;
      to_cnt        <= '0;
      up            <= 1'b1;
      idx           <= '0;
      posicao       <= '0;
      distancia     <= '0;
      medir         <= 1'b0;
      tx_partida    <= 1'b0;
      tx_dados      <= '0;
      fim_varredura <= 1'b0;
    end else begin
      medir         <= 1'b0;
      tx_partida    <= 1'b0;
      fim_varredura <= 1'b0;
      case (state)
        OCIOSO: begin
          settle_cnt <= '0;
          if (ligar) state <= POSICIONA;
        end
        POSICIONA: begin
          if (settle_cnt == 32'(INTERVALO - 1)) begin
            settle_cnt <= '0;
            state      <= MEDE;
          end else begin
            settle_cnt <= settle_cnt + 32'd1;
          end
        end
        MEDE: begin
          medir  <= 1'b1;
          to_cnt <= '0;
          state  <= ESPERA;
        end
        ESPERA: begin
          // A measurement arriving in the timeout cycle takes priority.
          if (pronto_medida) begin
            distancia <= medida;
            idx       <= '0;
            state     <= TRANSMITE;
          end else if (to_cnt == 32'(TIMEOUT - 1)) begin
            distancia <= 12'hFFF;
            idx       <= '0;
            state     <= TRANSMITE;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        TRANSMITE: begin
          tx_dados   <= frame_char;
          tx_partida <= 1'b1;
          state      <= AGUARDA_TX;
        end
        AGUARDA_TX: begin
          if (tx_pronto) begin
            if (idx == 3'd7) begin
              state <= PROXIMO;
            end else begin
              idx   <= idx + 3'd1;
              state <= TRANSMITE;
            end
          end
        end
        PROXIMO: begin
          if (N_POS == 1) begin
            posicao       <= '0;
            fim_varredura <= 1'b1;
          end else if (MODO == 1) begin
            if (posicao == LAST) begin
              posicao       <= '0;
              fim_varredura <= 1'b1;
            end else begin
              posicao <= posicao + ONE;
            end
          end else if (up) begin
            // Flip direction on arrival so the end point is not repeated.
            posicao <= posicao + ONE;
            if (posicao == LAST_M1) begin
              up            <= 1'b0;
              fim_varredura <= 1'b1;
            end
          end else begin
            posicao <= posicao - ONE;
            if (posicao == ONE) begin
              up            <= 1'b1;
              fim_varredura <= 1'b1;
            end
          end
          state <= ligar ? POSICIONA : OCIOSO;
        end
        default: state <= OCIOSO;
      endcase
    end
  end

endmodule
